// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file widths, the zero-register index and the write request type
package rf_pkg;
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int ZERO_REG = 0;
  typedef struct packed {
    logic [RF_ADDR_W-1:0] idx;
    logic [RF_DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/rf_late_fifo.sv
// rf_late_fifo: DEPTH-entry synchronous FIFO with async reset; caller never pushes when full or pops when empty
module rf_late_fifo #(
  parameter int W = 37,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wp] <= din;
  assign dout = mem[rp];
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: merges pipeline writeback and a buffered late source onto the register file write port, with a pending scoreboard.
// Optional RF_WRITE_ARBITER_BYPASS_EN adds forwarding outputs for the registered write.
module rf_write_arbiter import rf_pkg::*; #(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_valid,
  input  logic [ADDR_W-1:0] pipe_reg,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              late_valid,
  output logic              late_ready,
  input  logic [ADDR_W-1:0] late_reg,
  input  logic [DATA_W-1:0] late_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic [ADDR_W-1:0] query1,
  input  logic [ADDR_W-1:0] query2,
  output logic              busy1,
  output logic              busy2,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data
`ifdef RF_WRITE_ARBITER_BYPASS_EN
  ,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic [DATA_W-1:0] fwd2_data
`endif
);
  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);
  logic full, empty, push, pop, pipe_go;
  logic [ADDR_W+DATA_W-1:0] head;
  logic [ADDR_W-1:0] head_reg;
  logic [DATA_W-1:0] head_data;
  logic [NREG-1:1] pending, pending_n;
  logic [NREG-1:0] pend_all;
  rf_late_fifo #(.W(ADDR_W+DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din({late_reg, late_data}),
    .pop(pop), .dout(head), .full(full), .empty(empty)
  );
  assign {head_reg, head_data} = head;
  assign late_ready = !rst && !full;
  assign pipe_go = pipe_valid && pipe_reg != ZR;
  // late writes to register 0 are accepted but never stored
  assign push = late_valid && late_ready && late_reg != ZR;
  assign pop = !pipe_go && !empty;
  always_comb begin
    pending_n = pending;
    for (int i = 1; i < NREG; i++)
      pending_n[i] = (issue_valid && issue_reg == ADDR_W'(i)) ||
                     (pending[i] && !(pop && head_reg == ADDR_W'(i)));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write <= 1'b0;
      write_reg <= '0;
      write_data <= '0;
      pending <= '0;
    end else begin
      reg_write <= pipe_go || pop;
      write_reg <= pipe_go ? pipe_reg : pop ? head_reg : write_reg;
      write_data <= pipe_go ? pipe_data : pop ? head_data : write_data;
      pending <= pending_n;
    end
  end
  assign pend_all = {pending, 1'b0};
  assign busy1 = pend_all[query1];
  assign busy2 = pend_all[query2];
`ifdef RF_WRITE_ARBITER_BYPASS_EN
  assign fwd1_hit = reg_write && write_reg == query1 && query1 != ZR;
  assign fwd2_hit = reg_write && write_reg == query2 && query2 != ZR;
  assign fwd1_data = write_data;
  assign fwd2_data = write_data;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed and random stimulus checked against a queue-based reference model
module tb_rf_write_arbiter;
  import rf_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 0;
  logic pipe_valid = 0, late_valid = 0, issue_valid = 0;
  logic [4:0] pipe_reg = 0, late_reg = 0, issue_reg = 0, query1 = 0, query2 = 0;
  logic [31:0] pipe_data = 0, late_data = 0;
  logic late_ready, busy1, busy2, reg_write;
  logic [4:0] write_reg;
  logic [31:0] write_data;
`ifdef RF_WRITE_ARBITER_BYPASS_EN
  logic fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
`endif
  rf_write_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pipe_valid(pipe_valid), .pipe_reg(pipe_reg), .pipe_data(pipe_data),
    .late_valid(late_valid), .late_ready(late_ready), .late_reg(late_reg), .late_data(late_data),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .query1(query1), .query2(query2),
    .busy1(busy1), .busy2(busy2), .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data)
`ifdef RF_WRITE_ARBITER_BYPASS_EN
    , .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
`endif
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  wr_req_t q[$];
  bit pend[32];
  bit exp_we;
  logic [4:0] exp_reg;
  logic [31:0] exp_data;
  int writes_seen;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    foreach (pend[i]) pend[i] = 0;
    exp_we = 0;
    exp_reg = 0;
    exp_data = 0;
  endtask
  // inputs are applied 1 time unit after a rising edge; comb outputs checked, then model and registered outputs advance
  task automatic step(input bit pv, input logic [4:0] pr, input logic [31:0] pd,
                      input bit lv, input logic [4:0] lr, input logic [31:0] ld,
                      input bit iv, input logic [4:0] ir, input logic [4:0] q1, input logic [4:0] q2);
    bit acc;
    wr_req_t h;
    pipe_valid = pv; pipe_reg = pr; pipe_data = pd;
    late_valid = lv; late_reg = lr; late_data = ld;
    issue_valid = iv; issue_reg = ir; query1 = q1; query2 = q2;
    #1;
    check("late_ready", late_ready, q.size() < DEPTH);
    check("busy1", busy1, q1 != 0 && pend[q1]);
    check("busy2", busy2, q2 != 0 && pend[q2]);
`ifdef RF_WRITE_ARBITER_BYPASS_EN
    check("fwd1_hit", fwd1_hit, exp_we && exp_reg == q1 && q1 != 0);
    check("fwd2_hit", fwd2_hit, exp_we && exp_reg == q2 && q2 != 0);
    if (exp_we && exp_reg == q2 && q2 != 0) check("fwd2_data", fwd2_data, exp_data);
`endif
    acc = lv && q.size() < DEPTH;
    if (pv && pr != 0) begin
      exp_we = 1; exp_reg = pr; exp_data = pd;
    end else if (q.size() > 0) begin
      h = q.pop_front();
      exp_we = 1; exp_reg = h.idx; exp_data = h.data;
      pend[h.idx] = 0;
    end else exp_we = 0;
    if (acc && lr != 0) q.push_back('{idx: lr, data: ld});
    if (iv && ir != 0) pend[ir] = 1;
    @(posedge clk);
    #1;
    check("reg_write", reg_write, exp_we);
    check("write_reg", write_reg, exp_reg);
    check("write_data", write_data, exp_data);
    if (reg_write) begin
      writes_seen++;
      check("no_r0_write", write_reg != 0, 1);
    end
  endtask
  task automatic idle(input int n, input logic [4:0] q1, input logic [4:0] q2);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, q1, q2);
  endtask
  task automatic do_reset(input logic [4:0] q1);
    rst = 1;
    #1;
    check("rst_reg_write", reg_write, 0);
    check("rst_write_reg", write_reg, 0);
    check("rst_write_data", write_data, 0);
    check("rst_late_ready", late_ready, 0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_late_ready_held", late_ready, 0);
    rst = 0;
    query1 = q1;
    #1;
    check("rst_busy1", busy1, 0);
  endtask
  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset(0);
    // reset mid-stream: three queued entries and r5 pending
    step(0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
    for (int i = 0; i < 3; i++) step(1, 1, i, 1, 5'(10 + i), 32'h100 + i, 0, 0, 5, 0);
    check("pre_rst_queued", q.size(), 3);
    do_reset(5);
    writes_seen = 0;
    idle(6, 5, 0);
    check("rst_no_queued_write", writes_seen, 0);
    // pipe priority
    step(1, 3, 32'hA5A5A5A5, 1, 4, 32'h1234, 0, 0, 0, 0);
    check("prio_pipe_reg", write_reg, 3);
    step(1, 6, 32'h66, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("prio_late_reg", write_reg, 4);
    check("prio_late_data", write_data, 32'h1234);
    // fill FIFO behind a busy pipe, then drain
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 5'(20 + i), 32'h200 + i, 0, 0, 0, 0);
    check("full_ready_low", late_ready, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("drain_order", write_reg, 20 + i);
    end
    // scoreboard set, clear on pop, and re-issue in the pop cycle
    step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    step(1, 2, 0, 1, 7, 32'h77, 0, 0, 7, 0);
    check("sb_busy_set", busy1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    check("sb_busy_clear", busy1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    step(1, 2, 0, 1, 7, 32'h78, 0, 0, 7, 0);
    step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    check("sb_set_wins", busy1, 1);
    // register 0 everywhere
    writes_seen = 0;
    for (int i = 0; i < 5; i++) step(1, 0, 32'hF0, 1, 0, 32'hF1, 1, 0, 0, 0);
    check("r0_no_write", writes_seen, 0);
    check("r0_queue_empty", q.size(), 0);
    // forwarding on r9
    step(1, 9, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 9);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    // random traffic with one mid-stream reset
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset(5'($urandom_range(0, 31)));
      step($urandom_range(0, 99) < 45, 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 99) < 50, 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 99) < 30, 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Single write-port initiator for the 32x32 register file.
- Merges two result sources onto the file's write interface (reg_write, write_reg, write_data):
  - the in-order pipeline writeback;
  - a late source (multi-cycle mul/div, late loads) buffered in a small FIFO.
- Keeps a per-register pending scoreboard so decode can stall on registers with a late result still outstanding.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width (2**ADDR_W registers)
- DEPTH, 4, late-result FIFO entries; power of two, >= 2

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- pipe_valid  input  1  pipeline writeback valid this cycle
- pipe_reg  input  ADDR_W  pipeline destination register
- pipe_data  input  DATA_W  pipeline result
- late_valid  input  1  late result offered
- late_ready  output  1  late result accepted when late_valid & late_ready
- late_reg  input  ADDR_W  late destination register
- late_data  input  DATA_W  late result
- issue_valid  input  1  a late operation is issued this cycle
- issue_reg  input  ADDR_W  its destination register (marks it pending)
- query1  input  ADDR_W  decode source register 1
- query2  input  ADDR_W  decode source register 2
- busy1  output  1  query1 has an outstanding late write
- busy2  output  1  query2 has an outstanding late write
- reg_write  output  1  register file write enable (registered)
- write_reg  output  ADDR_W  register file write index (registered)
- write_data  output  DATA_W  register file write data (registered)

Behaviour:
- Reset (async, rst=1):
  - reg_write=0, write_reg=0, write_data=0.
  - FIFO empty, all pending bits clear.
  - late_ready=0 while rst is high.
  - Reset mid-operation discards queued entries and clears the scoreboard.
- Output stage: registered; a write presented in cycle N drives reg_write in cycle N+1 only (one-cycle pulse per write).
- Priority: pipeline always wins.
  - pipe_valid & pipe_reg!=0 -> output loads the pipe write; FIFO does not pop.
  - Otherwise, if the FIFO is non-empty -> pop the head into the output.
  - Otherwise reg_write=0 next cycle; write_reg/write_data hold their last values.
- Register 0:
  - Any write to index 0 never asserts reg_write.
  - A pipe write to 0 counts as idle, so the FIFO may pop.
  - A late write to 0 is accepted and dropped, never enqueued.
  - issue_reg=0 never sets a pending bit.
- FIFO:
  - late_ready = !full (combinational from the count), 0 during reset.
  - Push and pop in the same cycle are allowed when non-empty; the count is unchanged.
  - No pop-through when empty: accepted in cycle N, earliest reg_write is cycle N+2.
  - Pointers are ADDR-agnostic, $clog2(DEPTH) bits, wrapping naturally; count is $clog2(DEPTH)+1 bits.
- Scoreboard: pending[2**ADDR_W-1:1].
  - Set on issue_valid.
  - Cleared when that register's late write is popped into the output stage.
  - Set and clear of the same register in the same cycle: set wins.
  - Pipe writes never clear pending.
- busy1/busy2: combinational = pending[query], 0 for index 0.
- Starvation: the late source drains only on pipeline bubbles. This is acceptable by design; busy stalls create the bubbles.

Optional Feature:
- Macro: RF_WRITE_ARBITER_BYPASS_EN.
- Defined:
  - Adds outputs fwd1_hit, fwd2_hit (1 bit) and fwd1_data, fwd2_data (DATA_W).
  - fwdN_hit = reg_write & write_reg==queryN & queryN!=0; fwdN_data = write_data.
  - Decode selects fwdN_data over the register file value when fwdN_hit is set.
- Undefined: ports absent; decode relies on register file write-then-read timing.

Decomposition:
- Package rf_pkg: ADDR_W/DATA_W defaults, ZERO_REG constant, typedef for a write request struct {reg index, data}.
- One natural sub-module, rf_late_fifo: DEPTH-entry sync FIFO with push/pop/full/empty, async reset. The arbiter instantiates it.

Test Plan:
- Reset: assert rst mid-stream with 3 entries queued and pending[5] set -> reg_write=0, late_ready=0 during reset, busy1=0 for query1=5 after release, no queued write ever appears.
- Pipe priority: pipe write r3=0xA5A5A5A5 and late r4=0x1234 offered in the same cycle -> next cycle reg_write with r3/0xA5A5A5A5; r4/0x1234 appears only after the first pipe bubble.
- FIFO full: 4 late pushes while the pipe is valid every cycle -> late_ready=0 after the 4th. Pipe idle -> drains r-order in 4 consecutive cycles, and late_ready rises the cycle after the first pop.
- Scoreboard: issue r7, query1=7 -> busy1=1. The late r7 write is popped -> busy1=0 the next cycle. Issuing r7 again in the same pop cycle -> busy1 stays 1.
- Register 0: pipe_reg=0, late_reg=0, issue_reg=0 -> reg_write never asserts, busy for query 0 always 0, FIFO count unchanged.
- BYPASS_EN: write r9=0xDEADBEEF with query2=9 -> fwd2_hit=1, fwd2_data=0xDEADBEEF in the reg_write cycle only.
